// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_REL = 8'hF0;
    parameter int KEYCODE_W = 9;
endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 serial receiver: synchronizers, clock glitch filter, 11-bit frame FSM
// with odd-parity/stop checking and an inter-bit timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       resetN_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       frame_err_o
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q, strobe_q;
    logic [FW-1:0] flt_cnt_q;
    logic          flip, bit_in;

    assign flip   = clk_sync_q[1] != filt_q;
    assign bit_in = dat_sync_q[1];

    // The filtered clock only follows the pin after FILTER_LEN agreeing samples.
    always_ff @(posedge clk_i or negedge resetN_i) begin
        if (!resetN_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            flt_cnt_q  <= '0;
            strobe_q   <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_data_i};
            strobe_q   <= 1'b0;
            if (!flip) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                flt_cnt_q <= '0;
                filt_q    <= clk_sync_q[1];
                strobe_q  <= ~clk_sync_q[1];
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    rx_state_t     state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q, byte_vld_q, frame_err_q;
    logic [TW-1:0] tmo_q;

    always_ff @(posedge clk_i or negedge resetN_i) begin
        if (!resetN_i) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (state_q == IDLE || strobe_q) tmo_q <= '0;
            else                             tmo_q <= tmo_q + 1'b1;

            if (state_q != IDLE && !strobe_q && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_q     <= IDLE;
                shift_q     <= '0;
                frame_err_q <= 1'b1;
            end else if (strobe_q) begin
                case (state_q)
                    IDLE: if (!bit_in) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                    end
                    DATA: begin
                        shift_q   <= {bit_in, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_q   <= bit_in;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (bit_in && (^shift_q ^ par_q)) byte_vld_q  <= 1'b1;
                        else                              frame_err_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // shift_q is frozen in IDLE, so it stays valid alongside byte_vld_o.
    assign byte_o      = shift_q;
    assign byte_vld_o  = byte_vld_q;
    assign frame_err_o = frame_err_q;
endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: E0/F0 prefix decoding into make/break strobes and
// an active-low held level for one watched key.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int                   FILTER_LEN     = 8,
    parameter int                   TIMEOUT_CYCLES = 50000,
    parameter logic [KEYCODE_W-1:0] WATCH_CODE     = 9'h029
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 ps2Clk,
    input  logic                 ps2Data,
    output logic [KEYCODE_W-1:0] keyCode,
    output logic                 makeP,
    output logic                 breakP,
    output logic                 keyN,
    output logic                 frameErrP
);
    logic [7:0] rx_byte;
    logic       rx_vld, rx_err;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i      (clk),
        .resetN_i   (resetN),
        .ps2_clk_i  (ps2Clk),
        .ps2_data_i (ps2Data),
        .byte_o     (rx_byte),
        .byte_vld_o (rx_vld),
        .frame_err_o(rx_err)
    );

    logic                 ext_q, rel_q, make_q, break_q, keyN_q;
    logic [KEYCODE_W-1:0] code_q, code_d;

    assign code_d = {ext_q, rx_byte};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ext_q   <= 1'b0;
            rel_q   <= 1'b0;
            make_q  <= 1'b0;
            break_q <= 1'b0;
            keyN_q  <= 1'b1;
            code_q  <= '0;
        end else begin
            make_q  <= 1'b0;
            break_q <= 1'b0;
            if (rx_err) begin
                ext_q <= 1'b0;
                rel_q <= 1'b0;
            end else if (rx_vld) begin
                if (rx_byte == PS2_EXT) begin
                    ext_q <= 1'b1;
                end else if (rx_byte == PS2_REL) begin
                    rel_q <= 1'b1;
                end else begin
                    code_q  <= code_d;
                    make_q  <= ~rel_q;
                    break_q <= rel_q;
                    ext_q   <= 1'b0;
                    rel_q   <= 1'b0;
                    // Release raises keyN; typematic makes simply re-clear it.
                    if (code_d == WATCH_CODE) keyN_q <= rel_q;
                end
            end
        end
    end

    assign keyCode   = code_q;
    assign makeP     = make_q;
    assign breakP    = break_q;
    assign keyN      = keyN_q;
    assign frameErrP = rx_err;
endmodule
